// File: rtl/core_hazard_ctrl_if.sv
// core_hazard_ctrl_if: decode-side hazard inputs and exec-side bypass/stall outputs
interface core_hazard_ctrl_if #(parameter int REG_ADDR_W = 5);
  logic                  i_stall_ext;
  logic                  i_flush;
  logic                  i_dec_valid;
  logic [REG_ADDR_W-1:0] i_dec_rs1;
  logic [REG_ADDR_W-1:0] i_dec_rs2;
  logic                  i_dec_rs1_used;
  logic                  i_dec_rs2_used;
  logic [REG_ADDR_W-1:0] i_dec_rd;
  logic                  i_dec_rd_we;
  logic                  i_dec_is_load;
  logic [1:0]            o_bp_rs1;
  logic [1:0]            o_bp_rs2;
  logic                  o_stall_dec;
  logic                  o_bubble_exec;
  modport master (
    output i_stall_ext, i_flush, i_dec_valid, i_dec_rs1, i_dec_rs2, i_dec_rs1_used,
           i_dec_rs2_used, i_dec_rd, i_dec_rd_we, i_dec_is_load,
    input  o_bp_rs1, o_bp_rs2, o_stall_dec, o_bubble_exec
  );
  modport slave (
    input  i_stall_ext, i_flush, i_dec_valid, i_dec_rs1, i_dec_rs2, i_dec_rs1_used,
           i_dec_rs2_used, i_dec_rd, i_dec_rd_we, i_dec_is_load,
    output o_bp_rs1, o_bp_rs2, o_stall_dec, o_bubble_exec
  );
endinterface

// File: rtl/core_hazard_ctrl.sv
// core_hazard_ctrl: destination scoreboard (EX/MEM/WR/WB) driving registered bypass selects
// and the single-cycle load-use stall between decode and exec.
module core_hazard_ctrl #(
  parameter int REG_ADDR_W     = 5,
  parameter int LOAD_USE_STALL = 1
) (
  input logic               i_clk,
  input logic               i_reset,
  core_hazard_ctrl_if.slave hz
);
  if (LOAD_USE_STALL != 1) begin : g_chk
    $error("core_hazard_ctrl: only LOAD_USE_STALL == 1 is supported");
  end
  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] rd;
    logic                  ld;
  } sb_t;
  sb_t        sb_q [4];
  sb_t        ex_d;
  logic [1:0] bp1_q, bp2_q, bp1_d, bp2_d;
  logic       bub_q, haz, stall, load;
  function automatic logic hit(input sb_t e, input logic [REG_ADDR_W-1:0] rs);
    return e.we && (e.rd == rs);
  endfunction
  // youngest producer wins; WB needs no bypass since the register file writes through
  function automatic logic [1:0] sel(input logic [REG_ADDR_W-1:0] rs, input logic used,
                                     input sb_t ex, input sb_t mem, input sb_t wr);
    return (!used || rs == '0) ? 2'b00 :
           hit(ex, rs)  ? 2'b01 :
           hit(mem, rs) ? 2'b10 :
           hit(wr, rs)  ? 2'b11 : 2'b00;
  endfunction
  always_comb begin
    haz   = hz.i_dec_valid && sb_q[0].we && sb_q[0].ld &&
            ((hz.i_dec_rs1_used && hz.i_dec_rs1 == sb_q[0].rd) ||
             (hz.i_dec_rs2_used && hz.i_dec_rs2 == sb_q[0].rd));
    stall = haz && !hz.i_flush && !i_reset;
    load  = hz.i_dec_valid && !stall && !hz.i_flush;
    ex_d  = load ? sb_t'{we: hz.i_dec_rd_we && hz.i_dec_rd != '0, rd: hz.i_dec_rd, ld: hz.i_dec_is_load}
                 : sb_t'('0);
    bp1_d = load ? sel(hz.i_dec_rs1, hz.i_dec_rs1_used, sb_q[0], sb_q[1], sb_q[2]) : 2'b00;
    bp2_d = load ? sel(hz.i_dec_rs2, hz.i_dec_rs2_used, sb_q[0], sb_q[1], sb_q[2]) : 2'b00;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sb_q  <= '{default: '0};
      bp1_q <= 2'b00;
      bp2_q <= 2'b00;
      bub_q <= 1'b1;
    end else if (!hz.i_stall_ext) begin
      sb_q[0] <= ex_d;
      sb_q[1] <= sb_q[0];
      sb_q[2] <= sb_q[1];
      sb_q[3] <= sb_q[2];
      bp1_q   <= bp1_d;
      bp2_q   <= bp2_d;
      bub_q   <= !load;
    end
  end
  assign hz.o_bp_rs1      = bp1_q;
  assign hz.o_bp_rs2      = bp2_q;
  assign hz.o_stall_dec   = stall;
  assign hz.o_bubble_exec = bub_q;
endmodule

// File: doc/core_hazard_ctrl.md
Name: core_hazard_ctrl

Overview:
Generates the per-operand bypass selects consumed by the execute-stage operand mux, plus the load-use stall/bubble controls. Tracks destination-register state for the exec, memory, write and write_back stages in an internal scoreboard pipeline. Compares the decode-stage source registers against that scoreboard and registers the resulting selects so they are stable for the whole exec cycle. Sits between decode and exec, driven by the same pipeline advance/flush signals as the datapath.

Parameters:
- REG_ADDR_W, 5, register index width.
- LOAD_USE_STALL, 1, cycles inserted on load-use hazard. Only 1 is supported.

Ports:
- i_clk  in  1  core clock
- i_reset  in  1  synchronous, active-high reset
- i_stall_ext  in  1  global freeze (memory wait); all state holds
- i_flush  in  1  taken branch/trap; kills the decode instruction
- i_dec_valid  in  1  decode-stage instruction valid
- i_dec_rs1  in  5  decode rs1 index
- i_dec_rs2  in  5  decode rs2 index
- i_dec_rs1_used  in  1  rs1 is a real operand
- i_dec_rs2_used  in  1  rs2 is a real operand
- i_dec_rd  in  5  decode rd index
- i_dec_rd_we  in  1  instruction writes rd
- i_dec_is_load  in  1  instruction is a load (rd valid from write stage only)
- o_bp_rs1  out  2  exec-stage rs1 select (STAGED_BP_* encoding)
- o_bp_rs2  out  2  exec-stage rs2 select
- o_stall_dec  out  1  hold fetch/decode this cycle
- o_bubble_exec  out  1  exec stage holds a bubble this cycle (registered)

Behaviour:
Bypass select encoding:
- 2'b00 none: use the register file value.
- 2'b01 STAGED_BP_MEMORY.
- 2'b10 STAGED_BP_WRITE.
- 2'b11 STAGED_BP_WRITE_BK.

Scoreboard:
- Four entries: EX, MEM, WR, WB. Each entry holds {valid_we, rd, is_load}.
- advance = !i_stall_ext.
- On advance: WB<=WR, WR<=MEM, MEM<=EX.
- EX <= decode entry when i_dec_valid && !o_stall_dec && !i_flush. Otherwise EX <= bubble (valid_we=0).
- Any entry with rd==0 is stored with valid_we=0. x0 is never a forwarding source.

Select computation (at decode, for each used source rsN != 0), registered into o_bp_rsN on advance:
- Match EX entry (instruction will be in memory next cycle) -> MEMORY.
- Else match MEM entry -> WRITE.
- Else match WR entry -> WRITE_BK.
- Else none. The WB producer needs no bypass because the register file is write-through.
- Youngest match wins.
- An unused source or rsN==0 gives none.

Load-use hazard:
- Condition: EX.valid_we && EX.is_load && a used decode rsN==EX.rd && i_dec_valid.
- Effect: o_stall_dec=1 (combinational) and a bubble is inserted into EX.
- Next cycle the load is in MEM, the match resolves to WRITE, and the stall drops.
- Stall length is exactly 1 cycle.

Bubble and select outputs:
- o_bubble_exec = registered "EX loaded with bubble".
- When a bubble is loaded, o_bp_rs1/o_bp_rs2 are loaded with 00.

Simultaneous events:
- i_flush with a load-use condition: flush wins, o_stall_dec=0, EX gets a bubble.
- i_stall_ext: all registers hold, including o_bp_rs1/o_bp_rs2/o_bubble_exec. o_stall_dec is still asserted combinationally if a hazard exists.
- i_stall_ext && i_flush: the freeze wins. The flush must be held by its source until it is accepted.

Reset:
- Synchronous reset clears all scoreboard entries to bubble.
- Output reset values: o_bp_rs1=00, o_bp_rs2=00, o_bubble_exec=1, o_stall_dec=0.
- Reset asserted mid-hazard discards the pending stall; the first decode after reset sees an empty scoreboard.

Test Plan:
- ADD x5 followed directly by ADD using rs1=x5 -> next cycle o_bp_rs1=01, o_bp_rs2 per rs2, no stall.
- Producer of x7, then two unrelated instructions, then a consumer with rs2=x7 -> o_bp_rs2=11. With three unrelated instructions in between -> 00.
- LW x3 followed by ADD rs1=x3 -> o_stall_dec=1 for exactly one cycle, o_bubble_exec=1 on the next cycle, then o_bp_rs1=10 when the ADD enters exec.
- LW x3, ADD rs1=x3 with i_flush in the hazard cycle -> o_stall_dec=0, o_bubble_exec=1, o_bp_rs1=00.
- Producer writing x0 followed by a consumer with rs1=x0 -> o_bp_rs1=00. Producers of x9 in EX, MEM and WR all at once -> consumer gets 01 (youngest wins).
- i_stall_ext held for 3 cycles mid-stream -> all outputs constant, scoreboard unchanged, resumes correctly. Reset pulse during a load-use stall -> outputs go to reset values the next cycle.
